// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
// Holds the MDU op encodings (also used by the control unit to build
// `op` and `d_md_use`) and the MDU state constants.
package mdu_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5,
    MD_MFHI  = 3'd6,
    MD_MFLO  = 3'd7
  } md_op_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

  // Ops 0..3 are the multi-cycle multiply/divide group; bit 2 clear marks them.
  function automatic logic is_muldiv(input logic [2:0] op);
    return ~op[2];
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// mdu_calc: combinational 64-bit result generator for the MDU.
// Ports:
//   op       - MDU operation (only MULT/MULTU/DIV/DIVU produce a result)
//   a, b     - rs / rt operands
//   hi, lo   - upper/lower result words (remainder/quotient for divides)
//   div_zero - high when the op is a divide and the divisor is zero
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_zero
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        signed_div;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] div_den;
  logic [31:0] q_u;
  logic [31:0] r_u;
  logic        neg_q;
  logic        neg_r;

  // Signed divide is done on magnitudes with an unsigned divider and the
  // signs fixed up afterwards, so no signed-overflow corner reaches the
  // divider itself. The divisor is forced to 1 when zero so the divider
  // never sees /0; the result is discarded in that case anyway.
  always_comb begin
    hi         = '0;
    lo         = '0;
    prod_s     = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    prod_u     = {32'b0, a} * {32'b0, b};
    signed_div = (op == MD_DIV);
    mag_a      = (signed_div && a[31]) ? (~a + 32'd1) : a;
    mag_b      = (signed_div && b[31]) ? (~b + 32'd1) : b;
    div_den    = (b == 32'd0) ? 32'd1 : mag_b;
    q_u        = mag_a / div_den;
    r_u        = mag_a % div_den;
    neg_q      = signed_div & (a[31] ^ b[31]);
    neg_r      = signed_div & a[31];
    div_zero   = 1'b0;

    case (op)
      MD_MULT:  {hi, lo} = prod_s;
      MD_MULTU: {hi, lo} = prod_u;
      MD_DIV, MD_DIVU: begin
        div_zero = (b == 32'd0);
        lo       = neg_q ? (~q_u + 32'd1) : q_u;
        hi       = neg_r ? (~r_u + 32'd1) : r_u;
        // Most-negative / -1 overflows the quotient; it wraps to itself.
        if (signed_div && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          lo = 32'h8000_0000;
          hi = 32'd0;
        end
      end
      default: begin
        hi = '0;
        lo = '0;
      end
    endcase
  end

endmodule

// File: rtl/mdu.sv
// mdu: multiply/divide unit of the five-stage MIPS core, owning HI/LO.
// Ports:
//   clk      - rising-edge clock
//   reset    - asynchronous active-low reset, aborts any op in flight
//   start    - E-stage MDU op, already qualified by flush
//   op       - MDU operation (see mdu_pkg::md_op_e)
//   a, b     - forwarded rs / rt values
//   d_md_use - D-stage instruction is an MDU op
//   busy     - multiply/divide in flight
//   stall    - stall request to the hazard unit
//   mdu_res  - combinational HI (MFHI) / LO (MFLO) read value
module mdu
  import mdu_pkg::*;
#(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        d_md_use,
  output logic        busy,
  output logic        stall,
  output logic [31:0] mdu_res
);

  localparam int CW = $clog2(DIV_CYCLES) + 1;

  md_state_e   state;
  md_state_e   state_n;
  logic [CW-1:0] cnt;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic [31:0] calc_hi;
  logic [31:0] calc_lo;
  logic        calc_div_zero;
  logic        accept_md;
  logic        accept_mt;

  mdu_calc u_calc (
    .op       (op),
    .a        (a),
    .b        (b),
    .hi       (calc_hi),
    .lo       (calc_lo),
    .div_zero (calc_div_zero)
  );

  assign accept_md = (state == MD_IDLE) & start & is_muldiv(op);
  assign accept_mt = (state == MD_IDLE) & start & ((op == MD_MTHI) | (op == MD_MTLO));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= MD_IDLE;
    else        state <= state_n;
  end

  // Stall is gated by reset so a held reset silences the hazard request
  // even while start/d_md_use are still driven by the pipeline.
  always_comb begin
    state_n = state;
    busy    = (state == MD_RUN);
    stall   = reset & d_md_use & (busy | (start & is_muldiv(op)));
    case (state)
      MD_IDLE: if (accept_md) state_n = MD_RUN;
      MD_RUN:  if (cnt == '0) state_n = MD_IDLE;
      default: state_n = MD_IDLE;
    endcase
  end

  // Results are computed at acceptance and parked in res_hi/res_lo until
  // the busy window expires. A divide by zero parks the current HI/LO so
  // the commit leaves them unchanged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi     <= '0;
      lo     <= '0;
      res_hi <= '0;
      res_lo <= '0;
      cnt    <= '0;
    end else if (accept_md) begin
      cnt    <= op[1] ? CW'(DIV_CYCLES - 1) : CW'(MUL_CYCLES - 1);
      res_hi <= calc_div_zero ? hi : calc_hi;
      res_lo <= calc_div_zero ? lo : calc_lo;
    end else if (state == MD_RUN) begin
      if (cnt == '0) begin
        hi <= res_hi;
        lo <= res_lo;
      end else begin
        cnt <= cnt - CW'(1);
      end
    end else if (accept_mt) begin
      if (op == MD_MTHI) hi <= a;
      else               lo <= a;
    end
  end

  always_comb begin
    mdu_res = '0;
    if (op == MD_MFHI)      mdu_res = hi;
    else if (op == MD_MFLO) mdu_res = lo;
  end

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: self-checking bench for mdu. A cycle-level reference model tracks
// committed HI/LO and the pending mult/div result, and a negedge compare
// process checks busy/stall/mdu_res against it every cycle. Directed
// vectors add hand-computed literal checks.
module tb_mdu;
  import mdu_pkg::*;

  localparam int MUL_N = 5;
  localparam int DIV_N = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        d_md_use = 1'b0;
  logic        busy;
  logic        stall;
  logic [31:0] mdu_res;

  int vectors = 0;
  int miscompares = 0;

  mdu #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .d_md_use (d_md_use),
    .busy     (busy),
    .stall    (stall),
    .mdu_res  (mdu_res)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [31:0] p_hi = '0;
  logic [31:0] p_lo = '0;
  bit          pend = 1'b0;
  bit          p_zero = 1'b0;
  int          cyc = 0;
  int          commit_at = 0;
  longint      na, nb, nq, nr;
  logic [63:0] prod;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a mult/div accepted at edge k commits at edge k+N.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_hi = '0;
      m_lo = '0;
      pend = 1'b0;
    end else begin
      cyc++;
      if (pend) begin
        if (start) $display("[TB] FAIL start_while_busy: got start=1, expected 0");
        if (cyc == commit_at) begin
          if (!p_zero) begin
            m_hi = p_hi;
            m_lo = p_lo;
          end
          pend = 1'b0;
        end
      end else if (start) begin
        case (op)
          MD_MULT: begin
            prod = 64'(longint'($signed(a)) * longint'($signed(b)));
            {p_hi, p_lo} = prod;
          end
          MD_MULTU: begin
            prod = {32'b0, a} * {32'b0, b};
            {p_hi, p_lo} = prod;
          end
          MD_DIV, MD_DIVU: begin
            na = (op == MD_DIV) ? longint'($signed(a)) : longint'({32'b0, a});
            nb = (op == MD_DIV) ? longint'($signed(b)) : longint'({32'b0, b});
            p_zero = (nb == 0);
            if (nb != 0) begin
              nq = na / nb;
              nr = na % nb;
              p_lo = 32'(nq);
              p_hi = 32'(nr);
            end
          end
          MD_MTHI: m_hi = a;
          MD_MTLO: m_lo = a;
          default: ;
        endcase
        if (op <= 3'd3) begin
          if (op <= 3'd1) p_zero = 1'b0;
          pend = 1'b1;
          commit_at = cyc + ((op <= 3'd1) ? MUL_N : DIV_N);
        end
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    logic        e_stall;
    logic [31:0] e_res;
    e_stall = reset & d_md_use & (pend | (start & (op <= 3'd3)));
    e_res   = (op == MD_MFHI) ? m_hi : (op == MD_MFLO) ? m_lo : 32'd0;
    checkOutput("cyc_busy",  {31'b0, busy},  {31'b0, pend});
    checkOutput("cyc_stall", {31'b0, stall}, {31'b0, e_stall});
    checkOutput("cyc_res",   mdu_res,        e_res);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic [2:0] o, input logic [31:0] av,
                               input logic [31:0] bv, input logic dm);
    start    = s;
    op       = o;
    a        = av;
    b        = bv;
    d_md_use = dm;
  endtask

  task automatic runMd(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                       input logic dm, output int nbusy, output int nstall);
    applyStimulus(1'b1, o, av, bv, dm);
    tick();
    applyStimulus(1'b0, o, av, bv, dm);
    nbusy  = 0;
    nstall = 0;
    while (busy && nbusy < 64) begin
      nbusy++;
      if (stall) nstall++;
      tick();
    end
  endtask

  task automatic readHiLo(input string name, input logic [31:0] eh, input logic [31:0] el);
    applyStimulus(1'b0, MD_MFHI, 32'd0, 32'd0, 1'b0);
    #1;
    checkOutput({name, "_hi"}, mdu_res, eh);
    op = MD_MFLO;
    #1;
    checkOutput({name, "_lo"}, mdu_res, el);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int nb_, ns_;
    #2 reset = 1'b0;
    tick();
    // Reset state, including stall forced low while start/d_md_use are high
    applyStimulus(1'b1, MD_MULT, 32'd5, 32'd6, 1'b1);
    #1;
    checkOutput("reset_stall", {31'b0, stall}, 32'd0);
    checkOutput("reset_busy", {31'b0, busy}, 32'd0);
    readHiLo("reset", 32'd0, 32'd0);
    tick();
    reset = 1'b1;
    tick();

    // MULT signed -2 * 3
    runMd(MD_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0, nb_, ns_);
    checkOutput("mult_busy_len", nb_, MUL_N);
    checkOutput("mult_no_stall", ns_, 0);
    readHiLo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

    // DIVU 17 / 5
    runMd(MD_DIVU, 32'd17, 32'd5, 1'b0, nb_, ns_);
    checkOutput("divu_busy_len", nb_, DIV_N);
    readHiLo("divu", 32'd2, 32'd3);

    // DIV -7 / 2
    runMd(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, nb_, ns_);
    readHiLo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    // MTHI / MTLO preload then divide by zero
    applyStimulus(1'b1, MD_MTHI, 32'h1234, 32'd0, 1'b0);
    tick();
    applyStimulus(1'b1, MD_MTLO, 32'h5678, 32'd0, 1'b0);
    tick();
    readHiLo("mt", 32'h1234, 32'h5678);
    runMd(MD_DIV, 32'h99, 32'd0, 1'b0, nb_, ns_);
    checkOutput("div0_busy_len", nb_, DIV_N);
    readHiLo("div0", 32'h1234, 32'h5678);

    // Signed divide overflow
    runMd(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, nb_, ns_);
    readHiLo("div_ovf", 32'd0, 32'h8000_0000);

    // Stall held through a MULT
    applyStimulus(1'b1, MD_MULT, 32'd7, 32'd6, 1'b1);
    #1;
    checkOutput("stall_start_cycle", {31'b0, stall}, 32'd1);
    tick();
    applyStimulus(1'b0, MD_MULT, 32'd7, 32'd6, 1'b1);
    nb_ = 0;
    ns_ = 0;
    while (busy && nb_ < 64) begin
      nb_++;
      if (stall) ns_++;
      tick();
    end
    checkOutput("stall_busy_cycles", ns_, MUL_N);
    checkOutput("stall_after", {31'b0, stall}, 32'd0);
    readHiLo("stall_mult", 32'd0, 32'd42);

    // Back-to-back: MTLO right after the busy window ends
    runMd(MD_MULT, 32'h0001_0000, 32'h0003_0000, 1'b0, nb_, ns_);
    applyStimulus(1'b1, MD_MTLO, 32'd7, 32'd0, 1'b0);
    tick();
    readHiLo("b2b", 32'd3, 32'd7);

    // Reset in cycle 4 of a DIV
    applyStimulus(1'b1, MD_DIV, 32'd100, 32'd3, 1'b0);
    tick();
    applyStimulus(1'b0, MD_MFHI, 32'd100, 32'd3, 1'b0);
    tick();
    tick();
    tick();
    checkOutput("pre_reset_busy", {31'b0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("async_reset_busy", {31'b0, busy}, 32'd0);
    checkOutput("async_reset_hi", mdu_res, 32'd0);
    op = MD_MFLO;
    #1;
    checkOutput("async_reset_lo", mdu_res, 32'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    checkOutput("post_reset_idle", {31'b0, busy}, 32'd0);
    runMd(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, nb_, ns_);
    checkOutput("multu_busy_len", nb_, MUL_N);
    readHiLo("multu", 32'd1, 32'hFFFF_FFFE);

    tick();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit for the five-stage MIPS core. It sits in Execute beside the ALU and owns the HI/LO register pair. Its `mdu_res` output is carried through the E/M and M/W pipeline registers, and Writeback selects it as `mlu_res` (`regw_src == 4`) for MFHI/MFLO. Its multi-cycle busy window drives the hazard unit's stall.

## Interface
Parameters:
- `MUL_CYCLES`, default 5: busy length for MULT/MULTU.
- `DIV_CYCLES`, default 10: busy length for DIV/DIVU.

Ports:
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-low reset.
- `start` input 1: E-stage instruction is an MDU op, qualified by the pipeline not being flushed.
- `op` input 3: MDU operation. 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MFHI, 7 MFLO.
- `a` input 32: forwarded rs value.
- `b` input 32: forwarded rt value.
- `d_md_use` input 1: D-stage instruction is any MDU op.
- `busy` output 1: a multiply or divide is in flight.
- `stall` output 1: stall request to the hazard unit.
- `mdu_res` output 32: the HI or LO read value.

## Operation
- State machine states: IDLE and RUN. A counter `cnt` has width clog2(`DIV_CYCLES`)+1.
- **Starting mult/div.** When IDLE, `start` is high and `op` is 0 to 3:
  - operands are latched;
  - the 64-bit result is computed into `res_hi`/`res_lo`;
  - `cnt` loads `MUL_CYCLES`-1 or `DIV_CYCLES`-1;
  - the state goes to RUN.
- **RUN.** `cnt` decrements every cycle. When `cnt == 0`, HI/LO take `res_hi`/`res_lo` and the state returns to IDLE.
- **Multiply results.** MULT is signed 32x32 to 64. MULTU is unsigned. HI receives bits 63:32 and LO receives bits 31:0.
- **Divide results.** LO receives the quotient and HI the remainder. DIV truncates toward zero, and the remainder takes the sign of the dividend. DIVU is unsigned.
- **Divide edge cases.**
  - Divisor 0: HI/LO keep their previous values, and the full `DIV_CYCLES` busy window still runs.
  - DIV of 0x80000000 by 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- **MTHI/MTLO.** With `start` high and IDLE, HI or LO is written from `a` at the edge. There is no busy window.
- **MFHI/MFLO.** `mdu_res` is combinational: HI when `op` is 6, LO when `op` is 7, otherwise 0. It reflects committed HI/LO only.
- **Start while RUN.** Ignored, with no state change. The hazard unit guarantees this never happens; a bench assertion flags it.
- `busy` = (state == RUN).
- `stall` = `d_md_use` & (`busy` | (`start` & `op` <= 3)). The second term covers the cycle the op is still in E.
- **Reset.** Asynchronous, active-low, and it aborts any operation in flight:
  - HI, LO, `res_hi`, `res_lo` and `cnt` go to 0;
  - the state goes to IDLE;
  - `busy` and `stall` go to 0, and `mdu_res` reads 0.

## Timing
- A mult/div accepted at edge t raises `busy` for cycles t+1 through t+N, where N is `MUL_CYCLES` or `DIV_CYCLES`.
- HI/LO update at the edge ending cycle t+N. `busy` is low in cycle t+N+1, where MFHI/MFLO read the new value.
- MTHI/MTLO at edge t are visible on `mdu_res` in cycle t+1.
- MFHI/MFLO read latency: 0 cycles.
- Reset assertion forces all outputs low immediately, without waiting for a clock edge. Release takes effect synchronously at the next edge.

## Structure
- The shared macros/package holds the MDU op encodings (`MD_MULT` through `MD_MFLO`) and the state constants `MD_IDLE`/`MD_RUN`. CU imports the same encodings to generate `op` and `d_md_use`.
- The optional sub-module `mdu_calc` is the combinational 64-bit product plus quotient/remainder. It holds the divide-by-zero and overflow special cases. The `mdu` module keeps the FSM, the counter and HI/LO.

## Test plan
- **MULT signed.** `a` = 0xFFFFFFFE (-2), `b` = 3, start at t → `busy` high for cycles t+1..t+5; cycle t+6 MFHI = 0xFFFFFFFF, MFLO = 0xFFFFFFFA.
- **DIVU and DIV.**
  - DIVU `a` = 17, `b` = 5 → after 10 busy cycles, LO = 3 and HI = 2.
  - DIV `a` = -7, `b` = 2 → LO = 0xFFFFFFFD (-3), HI = 0xFFFFFFFF (-1).
- **Divide by zero.** Preload via MTHI 0x1234 / MTLO 0x5678, then DIV by 0 → `busy` high for 10 cycles; HI/LO still read 0x1234/0x5678.
- **Stall.**
  - `d_md_use` = 1 held through a MULT → `stall` is 1 in the start cycle and in all 5 busy cycles, and 0 afterward.
  - `d_md_use` = 0 → `stall` stays 0.
- **Reset mid-divide.** Drive `reset` low at cycle 4 of a DIV → `busy`, HI and LO are 0 immediately. After release the state is IDLE and a new MULTU 0xFFFFFFFF×2 yields HI = 1, LO = 0xFFFFFFFE.
- **Back-to-back.** MTLO 7 in the cycle right after a MULT busy window ends → LO = 7, and the MULT's HI is kept.
